// File: rtl/wb_commit_stage_pkg.sv
// wb_commit_stage_pkg: TLB op encodings, CSR numbers, FSM states and helpers for the WB/commit stage
package wb_commit_stage_pkg;
   localparam logic [2:0] TLBOP_NONE = 3'd0;
   localparam logic [2:0] TLBOP_SRCH = 3'd1;
   localparam logic [2:0] TLBOP_RD   = 3'd2;
   localparam logic [2:0] TLBOP_WR   = 3'd3;
   localparam logic [2:0] TLBOP_FILL = 3'd4;
   localparam logic [2:0] TLBOP_INV  = 3'd5;
   localparam logic [13:0] CSR_CRMD = 14'h0000;
   localparam logic [13:0] CSR_ASID = 14'h0018;

   typedef enum logic [1:0] {WB_IDLE, WB_REQ, WB_DONE} wb_state_e;

   function automatic logic tlbop_valid(input logic [2:0] op);
      return op != TLBOP_NONE && op <= TLBOP_INV;
   endfunction

   // Maximal-length Galois tap masks (right-shifting form), indexed by register width
   function automatic logic [31:0] lfsr_taps(input int w);
      logic [31:0] t;
      case (w)
         4:       t = 32'h0000_000C;
         5:       t = 32'h0000_0014;
         6:       t = 32'h0000_0030;
         7:       t = 32'h0000_0060;
         8:       t = 32'h0000_00B8;
         9:       t = 32'h0000_0110;
         10:      t = 32'h0000_0240;
         11:      t = 32'h0000_0500;
         12:      t = 32'h0000_0E08;
         13:      t = 32'h0000_1C80;
         14:      t = 32'h0000_3802;
         15:      t = 32'h0000_6000;
         16:      t = 32'h0000_B400;
         default: t = 32'h8020_0003;
      endcase
      return t;
   endfunction
endpackage

// File: rtl/wb_commit_stage_lfsr.sv
// wb_tlb_lfsr: free-running Galois LFSR supplying the tlbfill pseudo-random TLB index
module wb_tlb_lfsr
   import wb_commit_stage_pkg::*;
#(
   parameter int W     = 8,
   parameter int OUT_W = 4,
   parameter int SEED  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en_i,
   output logic [OUT_W-1:0] idx_o
);
   localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

   logic [W-1:0] lfsr_q, lfsr_d;

   always_comb lfsr_d = en_i ? ((lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0)) : lfsr_q;

   always_ff @(posedge clk) begin
      if (reset) lfsr_q <= W'(SEED);
      else       lfsr_q <= lfsr_d;
   end

   assign idx_o = lfsr_q[OUT_W-1:0];
endmodule

// File: rtl/wb_commit_stage.sv
// wb_commit_stage: WB/commit stage; commits RF/CSR writes, raises flushes, sequences TLB ops via req/ack
module wb_commit_stage
   import wb_commit_stage_pkg::*;
#(
   parameter int TLB_IDX_W = 4,
   parameter int RF_ADDR_W = 5,
   parameter int CSR_NUM_W = 14,
   parameter int LFSR_SEED = 'h1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ms_valid,
   output logic                 ws_allowin,
   input  logic [31:0]          ms_pc,
   input  logic                 ms_rf_we,
   input  logic [RF_ADDR_W-1:0] ms_rf_waddr,
   input  logic [31:0]          ms_result,
   input  logic                 ms_csr_re,
   input  logic                 ms_csr_we,
   input  logic [CSR_NUM_W-1:0] ms_csr_num,
   input  logic [31:0]          ms_csr_wmask,
   input  logic [31:0]          ms_csr_wvalue,
   input  logic                 ms_excp,
   input  logic [5:0]           ms_ecode,
   input  logic [8:0]           ms_esub,
   input  logic [31:0]          ms_vaddr,
   input  logic                 ms_ertn,
   input  logic [2:0]           ms_tlbop,
   input  logic                 ms_s1_found,
   input  logic [TLB_IDX_W-1:0] ms_s1_index,
   input  logic [31:0]          csr_rvalue,
   input  logic [TLB_IDX_W-1:0] csr_tlbidx_index,
   input  logic                 tlb_ack,
   output logic                 rf_we,
   output logic [RF_ADDR_W-1:0] rf_waddr,
   output logic [31:0]          rf_wdata,
   output logic                 ws_csr_we,
   output logic [CSR_NUM_W-1:0] ws_csr_num,
   output logic [31:0]          ws_csr_wmask,
   output logic [31:0]          ws_csr_wvalue,
   output logic                 excp_commit,
   output logic                 ertn_commit,
   output logic [5:0]           excp_ecode,
   output logic [8:0]           excp_esub,
   output logic [31:0]          excp_badv,
   output logic                 tlb_req,
   output logic [2:0]           tlb_op,
   output logic [TLB_IDX_W-1:0] tlb_w_index,
   output logic                 tlbsrch_we,
   output logic                 tlbsrch_hit,
   output logic [TLB_IDX_W-1:0] tlbsrch_hit_index,
   output logic                 flush,
   output logic [31:0]          refetch_pc,
   output logic                 refetch,
   output logic [31:0]          debug_wb_pc,
   output logic [3:0]           debug_wb_rf_we,
   output logic [RF_ADDR_W-1:0] debug_wb_rf_wnum,
   output logic [31:0]          debug_wb_rf_wdata
);
   logic                 ws_valid_q, ws_valid_d;
   logic [31:0]          ws_pc_q, ws_result_q, ws_csr_wmask_q, ws_csr_wvalue_q, ws_vaddr_q;
   logic                 ws_rf_we_q, ws_csr_re_q, ws_csr_we_q, ws_excp_q, ws_ertn_q, ws_s1_found_q;
   logic [RF_ADDR_W-1:0] ws_rf_waddr_q;
   logic [CSR_NUM_W-1:0] ws_csr_num_q;
   logic [5:0]           ws_ecode_q;
   logic [8:0]           ws_esub_q;
   logic [2:0]           ws_tlbop_q;
   logic [TLB_IDX_W-1:0] ws_s1_index_q, idx_q, idx_d, lfsr_idx;
   wb_state_e            state_q, state_d;
   logic                 tlb_go, ready_go, ld, cm, csr_map, refetch_cond;

   wb_tlb_lfsr #(.W(TLB_IDX_W + 4), .OUT_W(TLB_IDX_W), .SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .en_i  (1'b1),
      .idx_o (lfsr_idx)
   );

   assign tlb_go     = tlbop_valid(ws_tlbop_q) & ~ws_excp_q;
   assign ready_go   = ~tlb_go | (state_q == WB_DONE);
   assign ws_allowin = ~ws_valid_q | ready_go;
   assign ld         = ms_valid & ws_allowin;
   assign ws_valid_d = ld ? 1'b1 : ready_go ? 1'b0 : ws_valid_q;
   // Commit strobe: the single ready_go cycle of a valid instruction; reset masks it immediately
   assign cm         = ws_valid_q & ready_go & ~reset;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         WB_IDLE: begin
            if (ws_valid_q & tlb_go) begin
               state_d = WB_REQ;
               idx_d   = (ws_tlbop_q == TLBOP_FILL) ? lfsr_idx : csr_tlbidx_index;
            end
         end
         WB_REQ:  state_d = tlb_ack ? WB_DONE : WB_REQ;
         WB_DONE: state_d = WB_IDLE;
         default: state_d = WB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ws_valid_q      <= 1'b0;
         state_q         <= WB_IDLE;
         idx_q           <= '0;
         ws_pc_q         <= '0;
         ws_rf_we_q      <= 1'b0;
         ws_rf_waddr_q   <= '0;
         ws_result_q     <= '0;
         ws_csr_re_q     <= 1'b0;
         ws_csr_we_q     <= 1'b0;
         ws_csr_num_q    <= '0;
         ws_csr_wmask_q  <= '0;
         ws_csr_wvalue_q <= '0;
         ws_excp_q       <= 1'b0;
         ws_ecode_q      <= '0;
         ws_esub_q       <= '0;
         ws_vaddr_q      <= '0;
         ws_ertn_q       <= 1'b0;
         ws_tlbop_q      <= TLBOP_NONE;
         ws_s1_found_q   <= 1'b0;
         ws_s1_index_q   <= '0;
      end else begin
         ws_valid_q <= ws_valid_d;
         state_q    <= state_d;
         idx_q      <= idx_d;
         if (ld) begin
            ws_pc_q         <= ms_pc;
            ws_rf_we_q      <= ms_rf_we;
            ws_rf_waddr_q   <= ms_rf_waddr;
            ws_result_q     <= ms_result;
            ws_csr_re_q     <= ms_csr_re;
            ws_csr_we_q     <= ms_csr_we;
            ws_csr_num_q    <= ms_csr_num;
            ws_csr_wmask_q  <= ms_csr_wmask;
            ws_csr_wvalue_q <= ms_csr_wvalue;
            ws_excp_q       <= ms_excp;
            ws_ecode_q      <= ms_ecode;
            ws_esub_q       <= ms_esub;
            ws_vaddr_q      <= ms_vaddr;
            ws_ertn_q       <= ms_ertn;
            ws_tlbop_q      <= ms_tlbop;
            ws_s1_found_q   <= ms_s1_found;
            ws_s1_index_q   <= ms_s1_index;
         end
      end
   end

   assign rf_we         = cm & ws_rf_we_q & ~ws_excp_q;
   assign rf_waddr      = ws_rf_waddr_q;
   assign rf_wdata      = ws_csr_re_q ? csr_rvalue : ws_result_q;
   assign ws_csr_we     = cm & ws_csr_we_q & ~ws_excp_q;
   assign ws_csr_num    = ws_csr_num_q;
   assign ws_csr_wmask  = ws_csr_wmask_q;
   assign ws_csr_wvalue = ws_csr_wvalue_q;
   assign excp_commit   = cm & ws_excp_q;
   assign ertn_commit   = cm & ws_ertn_q & ~ws_excp_q;
   assign excp_ecode    = excp_commit ? ws_ecode_q : '0;
   assign excp_esub     = excp_commit ? ws_esub_q : '0;
   assign excp_badv     = excp_commit ? ws_vaddr_q : '0;

   assign tlb_req     = (state_q == WB_REQ) & ~reset;
   assign tlb_op      = tlb_req ? ws_tlbop_q : TLBOP_NONE;
   assign tlb_w_index = tlb_req ? idx_q : '0;

   assign tlbsrch_we        = cm & (state_q == WB_DONE) & (ws_tlbop_q == TLBOP_SRCH);
   assign tlbsrch_hit       = tlbsrch_we & ws_s1_found_q;
   assign tlbsrch_hit_index = tlbsrch_we ? ws_s1_index_q : '0;

   // TLB ops that change mappings, and writes to CRMD/ASID, force a refetch of pc+4
   assign csr_map      = ws_csr_we & (ws_csr_num_q == CSR_NUM_W'(CSR_CRMD) | ws_csr_num_q == CSR_NUM_W'(CSR_ASID));
   assign refetch_cond = (~ws_excp_q & (ws_tlbop_q inside {TLBOP_RD, TLBOP_WR, TLBOP_FILL, TLBOP_INV})) | csr_map;
   assign flush        = cm & (ws_excp_q | ws_ertn_q | refetch_cond);
   assign refetch      = flush & ~ws_excp_q & ~ws_ertn_q;
   assign refetch_pc   = refetch ? ws_pc_q + 32'd4 : '0;

   assign debug_wb_pc       = ws_pc_q;
   assign debug_wb_rf_we    = {4{rf_we}};
   assign debug_wb_rf_wnum  = ws_rf_waddr_q;
   assign debug_wb_rf_wdata = rf_wdata;
endmodule
